// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   owner_e       : which requester owns the current transaction
//   state_e       : arbiter FSM state
//   DMEM_ERR_DATA : read data returned on a timeout abort
package dmem_pkg;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DBG  = 1'b1
  } owner_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic [31:0] DMEM_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-input requester selector.
//   req[0]     : core request
//   req[1]     : debug request
//   last_owner : requester served by the previous transaction
//   owner      : selected requester (meaningful when valid)
//   valid      : at least one request pending
// CORE_PRIO=0 alternates on a tie; CORE_PRIO=1 always favours the core.
module rr_pick2
  import dmem_pkg::*;
#(
  parameter int unsigned CORE_PRIO = 0
) (
  input  logic [1:0] req,
  input  owner_e     last_owner,
  output owner_e     owner,
  output logic       valid
);

  always_comb begin
    valid = |req;
    owner = OWN_CORE;
    if (req == 2'b10) begin
      owner = OWN_DBG;
    end else if (req == 2'b11 && CORE_PRIO == 0 && last_owner == OWN_CORE) begin
      owner = OWN_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the core LSU and a debug/loader
// master. One transaction at a time: grant in IDLE, hold mem_req_o in BUSY
// until mem_ack_i or timeout, then return the response to the owner.
//   clk_i, rst_ni          : core clock, async active-low reset
//   core_* / dbg_*         : requester ports (req/we/addr/wdata/be in,
//                            gnt/rvalid/rdata out)
//   mem_*                  : memory port (req/we/addr/wdata/be out,
//                            ack/rdata in)
//   busy_o                 : transaction in flight
//   err_o                  : one-cycle pulse on timeout abort
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned CORE_PRIO = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,

  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [31:0]       core_wdata_i,
  input  logic [3:0]        core_be_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [31:0]       core_rdata_o,

  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [31:0]       dbg_wdata_i,
  input  logic [3:0]        dbg_be_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [31:0]       dbg_rdata_o,

  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_be_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i,

  output logic              busy_o,
  output logic              err_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state;
  owner_e           owner_q;
  owner_e           last_owner;
  logic [CNT_W-1:0] cnt;

  owner_e pick_owner;
  logic   pick_valid;
  logic   start;
  logic   ack_done;
  logic   tmo;
  logic   done;
  logic [31:0] rsp_data;

  rr_pick2 #(
    .CORE_PRIO (CORE_PRIO)
  ) u_pick (
    .req        ({dbg_req_i, core_req_i}),
    .last_owner (last_owner),
    .owner      (pick_owner),
    .valid      (pick_valid)
  );

  // Grant is gated by rst_ni so no output is asserted while held in reset.
  assign start = rst_ni && (state == ST_IDLE) && pick_valid;

  assign core_gnt_o = start && (pick_owner == OWN_CORE);
  assign dbg_gnt_o  = start && (pick_owner == OWN_DBG);

  // Ack has precedence over the timeout in the same cycle.
  assign ack_done = (state == ST_BUSY) && mem_ack_i;
  assign tmo      = (state == ST_BUSY) && !mem_ack_i && (cnt == CNT_LAST);
  assign done     = ack_done || tmo;

  always_comb begin
    rsp_data = '0;
    if (tmo) begin
      rsp_data = DMEM_ERR_DATA;
    end else if (!mem_we_o) begin
      rsp_data = mem_rdata_i;
    end
  end

  assign core_rvalid_o = done && (owner_q == OWN_CORE);
  assign dbg_rvalid_o  = done && (owner_q == OWN_DBG);
  assign core_rdata_o  = core_rvalid_o ? rsp_data : '0;
  assign dbg_rdata_o   = dbg_rvalid_o  ? rsp_data : '0;
  assign err_o         = tmo;
  assign busy_o        = (state == ST_BUSY);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_IDLE;
      owner_q     <= OWN_CORE;
      last_owner  <= OWN_DBG;
      cnt         <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (start) begin
            owner_q   <= pick_owner;
            mem_req_o <= 1'b1;
            state     <= ST_BUSY;
            if (pick_owner == OWN_CORE) begin
              mem_we_o    <= core_we_i;
              mem_addr_o  <= core_addr_i;
              mem_wdata_o <= core_wdata_i;
              mem_be_o    <= core_be_i;
            end else begin
              mem_we_o    <= dbg_we_i;
              mem_addr_o  <= dbg_addr_i;
              mem_wdata_o <= dbg_wdata_i;
              mem_be_o    <= dbg_be_i;
            end
          end
        end
        ST_BUSY: begin
          cnt <= cnt + CNT_W'(1);
          if (done) begin
            state       <= ST_IDLE;
            last_owner  <= owner_q;
            cnt         <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_be_o    <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter.
// u_dut : CORE_PRIO=0, TIMEOUT=8 ; u_prio : CORE_PRIO=1, TIMEOUT=64.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_rdata = '0;

  // main instance
  logic        core_req = 0, core_we = 0, dbg_req = 0, dbg_we = 0, mem_ack = 0;
  logic [15:0] core_addr = '0, dbg_addr = '0;
  logic [31:0] core_wdata = '0, dbg_wdata = '0;
  logic [3:0]  core_be = '0, dbg_be = '0;
  logic        core_gnt, core_rvalid, dbg_gnt, dbg_rvalid;
  logic [31:0] core_rdata, dbg_rdata, mem_wdata;
  logic        mem_req, mem_we, busy, err;
  logic [15:0] mem_addr;
  logic [3:0]  mem_be;

  // fixed-priority instance
  logic        p_core_req = 0, p_dbg_req = 0, p_mem_ack = 0;
  logic        p_core_gnt, p_core_rvalid, p_dbg_gnt, p_dbg_rvalid;
  logic [31:0] p_core_rdata, p_dbg_rdata, p_mem_wdata;
  logic        p_mem_req, p_mem_we, p_busy, p_err;
  logic [15:0] p_mem_addr;
  logic [3:0]  p_mem_be;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(16), .TIMEOUT(8), .CORE_PRIO(0)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
    .core_wdata_i(core_wdata), .core_be_i(core_be), .core_gnt_o(core_gnt),
    .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
    .dbg_wdata_i(dbg_wdata), .dbg_be_i(dbg_be), .dbg_gnt_o(dbg_gnt),
    .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_ack_i(mem_ack),
    .mem_rdata_i(mem_rdata), .busy_o(busy), .err_o(err)
  );

  dmem_arbiter #(.ADDR_W(16), .TIMEOUT(64), .CORE_PRIO(1)) u_prio (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_i(p_core_req), .core_we_i(1'b0), .core_addr_i(16'h0010),
    .core_wdata_i(32'h0), .core_be_i(4'hF), .core_gnt_o(p_core_gnt),
    .core_rvalid_o(p_core_rvalid), .core_rdata_o(p_core_rdata),
    .dbg_req_i(p_dbg_req), .dbg_we_i(1'b0), .dbg_addr_i(16'h0020),
    .dbg_wdata_i(32'h0), .dbg_be_i(4'hF), .dbg_gnt_o(p_dbg_gnt),
    .dbg_rvalid_o(p_dbg_rvalid), .dbg_rdata_o(p_dbg_rdata),
    .mem_req_o(p_mem_req), .mem_we_o(p_mem_we), .mem_addr_o(p_mem_addr),
    .mem_wdata_o(p_mem_wdata), .mem_be_o(p_mem_be), .mem_ack_i(p_mem_ack),
    .mem_rdata_i(mem_rdata), .busy_o(p_busy), .err_o(p_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_rdata", core_rdata | dbg_rdata, 0);
    chk("rst_rvalid", {30'd0, core_rvalid, dbg_rvalid}, 0);
    chk("rst_gnt", {30'd0, core_gnt, dbg_gnt}, 0);
    chk("rst_mem_fields", {mem_addr, 11'd0, mem_we, mem_be}, 0);
    @(negedge clk); rst_n = 1'b1;

    // 1: core read, ack two cycles after mem_req rises
    @(negedge clk);
    core_req = 1; core_we = 0; core_addr = 16'h0040; core_be = 4'hF;
    #1;
    chk("t1_gnt", {30'd0, core_gnt, dbg_gnt}, 32'b10);
    chk("t1_req_before", {31'd0, mem_req}, 0);
    @(negedge clk); core_req = 0; core_addr = 16'hFFFF;
    #1;
    chk("t1_req_t1", {31'd0, mem_req}, 1);
    chk("t1_addr", {16'd0, mem_addr}, 32'h0040);
    chk("t1_busy", {31'd0, busy}, 1);
    chk("t1_no_rvalid", {31'd0, core_rvalid}, 0);
    @(negedge clk); mem_ack = 1; mem_rdata = 32'h1234_5678;
    #1;
    chk("t1_req_t2", {31'd0, mem_req}, 1);
    chk("t1_rvalid", {31'd0, core_rvalid}, 1);
    chk("t1_rdata", core_rdata, 32'h1234_5678);
    chk("t1_dbg_quiet", {dbg_rdata[30:0], dbg_rvalid}, 0);
    chk("t1_err", {31'd0, err}, 0);
    @(negedge clk); mem_ack = 0;
    #1;
    chk("t1_req_drop", {30'd0, mem_req, busy}, 0);
    chk("t1_rvalid_drop", {31'd0, core_rvalid}, 0);

    // 2: both request continuously, round-robin, immediate ack
    pulse_reset();
    core_addr = 16'h0200; dbg_addr = 16'h0300;
    core_req = 1; dbg_req = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t2_gnt%0d", i), {30'd0, core_gnt, dbg_gnt},
          (i % 2 == 0) ? 32'b10 : 32'b01);
      @(negedge clk); mem_ack = 1; mem_rdata = 32'h5000_0000 + i;
      #1;
      chk($sformatf("t2_nognt%0d", i), {30'd0, core_gnt, dbg_gnt}, 0);
      chk($sformatf("t2_rv%0d", i), {30'd0, core_rvalid, dbg_rvalid},
          (i % 2 == 0) ? 32'b10 : 32'b01);
      chk($sformatf("t2_addr%0d", i), {16'd0, mem_addr},
          (i % 2 == 0) ? 32'h0200 : 32'h0300);
      @(negedge clk); mem_ack = 0;
    end
    core_req = 0; dbg_req = 0;

    // 3: fixed priority instance, core held high
    pulse_reset();
    p_core_req = 1; p_dbg_req = 1; mem_rdata = 32'h0000_00A5;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) p_core_req = 0;
      #1;
      chk($sformatf("t3_gnt%0d", i), {30'd0, p_core_gnt, p_dbg_gnt},
          (i < 3) ? 32'b10 : 32'b01);
      @(negedge clk); p_mem_ack = 1;
      #1;
      chk($sformatf("t3_rv%0d", i), {30'd0, p_core_rvalid, p_dbg_rvalid},
          (i < 3) ? 32'b10 : 32'b01);
      chk($sformatf("t3_rd%0d", i), p_core_rdata | p_dbg_rdata, 32'h0000_00A5);
      @(negedge clk); p_mem_ack = 0;
    end
    p_dbg_req = 0;

    // 4: debug write, never acked, TIMEOUT=8
    @(negedge clk);
    dbg_req = 1; dbg_we = 1; dbg_addr = 16'h0100; dbg_be = 4'b0011;
    dbg_wdata = 32'hAABB_CCDD;
    #1;
    chk("t4_gnt", {30'd0, core_gnt, dbg_gnt}, 32'b01);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      dbg_req = 0; dbg_wdata = 32'h0; dbg_be = 4'hF; dbg_addr = 16'h0;
      #1;
      chk($sformatf("t4_fields%0d", k), {mem_be, 3'd0, mem_we, 7'd0, mem_req, mem_addr},
          {4'b0011, 3'd0, 1'b1, 7'd0, 1'b1, 16'h0100});
      chk($sformatf("t4_wdata%0d", k), mem_wdata, 32'hAABB_CCDD);
      chk($sformatf("t4_err%0d", k), {30'd0, dbg_rvalid, err},
          (k == 7) ? 32'b11 : 32'b00);
      if (k == 7) begin
        chk("t4_rdata", dbg_rdata, 32'hDEAD_BEEF);
        chk("t4_core_quiet", {31'd0, core_rvalid}, 0);
      end
    end
    @(negedge clk); #1;
    chk("t4_idle", {29'd0, mem_req, busy, err}, 0);
    dbg_we = 0;

    // 5: ack exactly in the timeout cycle
    @(negedge clk); core_req = 1; core_addr = 16'h0044; #1;
    chk("t5_gnt", {31'd0, core_gnt}, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); core_req = 0;
      if (k == 7) begin mem_ack = 1; mem_rdata = 32'hCAFE_0001; end
      #1;
      chk($sformatf("t5_rv%0d", k), {30'd0, core_rvalid, err},
          (k == 7) ? 32'b10 : 32'b00);
    end
    chk("t5_rdata", core_rdata, 32'hCAFE_0001);
    @(negedge clk); mem_ack = 0;

    // 6: reset in the middle of BUSY
    @(negedge clk); core_req = 1; #1;
    chk("t6_gnt", {31'd0, core_gnt}, 1);
    @(negedge clk); core_req = 0; #1;
    chk("t6_busy", {30'd0, mem_req, busy}, 32'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_drop", {30'd0, mem_req, busy}, 0);
    chk("t6_no_rsp", {29'd0, core_rvalid, dbg_rvalid, err}, 0);
    @(negedge clk); rst_n = 1'b1; core_req = 1; dbg_req = 1; #1;
    chk("t6_first_tie", {30'd0, core_gnt, dbg_gnt}, 32'b10);
    @(negedge clk); core_req = 0; dbg_req = 0; mem_ack = 1; #1;
    chk("t6_rv", {30'd0, core_rvalid, dbg_rvalid}, 32'b10);
    @(negedge clk); mem_ack = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the single data-memory port between two requesters: the core LSU and a debug/program-loader master.
- Runs one transaction at a time: request latch, memory handshake, response return.
- Selects between requesters by round-robin or fixed priority.
- A timeout counter recovers the port from a memory that never acknowledges.
- Sits between the LSU/loader and the data RAM, clocked by the core clock.

Parameters:
- ADDR_W, 16, width of the byte address on all ports.
- TIMEOUT, 64, maximum cycles mem_req_o is held before the transaction is aborted (>=2).
- CORE_PRIO, 0, 0 = round-robin between requesters; 1 = core always wins a simultaneous request.

Ports:
- clk_i  in  1  core clock; single clock domain.
- rst_ni  in  1  asynchronous, active-low reset.
- core_req_i  in  1  core request; held until core_gnt_o.
- core_we_i  in  1  core write enable.
- core_addr_i  in  ADDR_W  core byte address.
- core_wdata_i  in  32  core store data.
- core_be_i  in  4  core byte enables.
- core_gnt_o  out  1  one-cycle grant; request fields are sampled in this cycle.
- core_rvalid_o  out  1  one-cycle completion pulse.
- core_rdata_o  out  32  load data, valid with core_rvalid_o.
- dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, dbg_be_i, dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o: same as core_*, for the debug master.
- mem_req_o  out  1  memory request; held until mem_ack_i.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  32  memory store data.
- mem_be_o  out  4  memory byte enables.
- mem_ack_i  in  1  memory completion; mem_rdata_i is valid in the same cycle.
- mem_rdata_i  in  32  memory read data.
- busy_o  out  1  high while state is BUSY.
- err_o  out  1  one-cycle pulse on a timeout abort.

Behaviour:
- Reset values:
  - State IDLE.
  - All *_o outputs 0, including all rdata outputs.
  - Timeout counter 0.
  - last_owner = DBG, so the core wins the first tie.
- FSM, IDLE:
  - If any req is high, pick the owner; its gnt is asserted combinationally in this cycle.
  - Latch owner, we, addr, wdata and be; go to BUSY.
  - With no request, stay in IDLE.
- Owner selection:
  - Only one req high: that requester.
  - Both high, CORE_PRIO=1: core.
  - Both high, CORE_PRIO=0: the requester that is not last_owner.
- FSM, BUSY:
  - mem_req_o=1 and mem_* driven from the latched fields, stable every cycle.
  - The counter increments each BUSY cycle.
- Completion:
  - When mem_ack_i=1: pulse the owner's rvalid for 1 cycle with rdata = mem_rdata_i (for writes, rdata = 0).
  - Set last_owner = owner; go to IDLE.
  - mem_req_o drops in the next cycle.
- Timeout:
  - Applies when the counter reaches TIMEOUT-1 with no ack.
  - Pulse the owner's rvalid with rdata = 32'hDEAD_BEEF and pulse err_o.
  - Update last_owner; go to IDLE.
- Ack and timeout in the same cycle: ack wins, normal completion, no err_o.
- Latency:
  - gnt occurs at cycle t; mem_req_o is high from t+1.
  - An ack at t+1 gives rvalid at t+1 (combinational from the ack).
  - Back-to-back rate is therefore one transaction per 2 cycles at best.
- No gnt is issued in BUSY; requests wait in IDLE, and the requester keeps req high.
- The non-selected requester sees gnt=0 and is served next under round-robin, so it cannot starve.
- Only the owner's rvalid/rdata ever toggle; the other requester's rvalid and rdata stay 0.
- Reset mid-transaction: everything returns to reset values immediately.
  - No rvalid and no err_o are produced for the aborted transaction.
  - mem_req_o drops asynchronously.
- The counter clears on every IDLE cycle; TIMEOUT applies per transaction.

Decomposition:
- Shared package dmem_pkg holds:
  - typedef owner_e {OWN_CORE, OWN_DBG};
  - typedef state_e {ST_IDLE, ST_BUSY};
  - the constant DMEM_ERR_DATA = 32'hDEAD_BEEF.
- One sub-module, rr_pick2: a two-input round-robin/fixed-priority selector (inputs req[1:0], last_owner, CORE_PRIO; output owner and valid).

Test Plan:
1. Core read, addr 0x0040, memory acks 2 cycles after mem_req_o rises, mem_rdata_i=0x1234_5678 -> core_gnt_o at t, mem_req_o high t+1..t+2, core_rvalid_o at t+2 with 0x1234_5678, dbg_* stays 0.
2. Core and dbg request together every cycle, CORE_PRIO=0, ack immediate -> grants alternate core, dbg, core, dbg, with one grant every 2 cycles.
3. Same stimulus with CORE_PRIO=1 and core_req_i held high -> every grant goes to the core; dbg is granted only once core_req_i drops.
4. Dbg write with be=4'b0011 and wdata=0xAABB_CCDD, no ack, TIMEOUT=8 -> mem_req_o held 8 cycles with stable fields, then dbg_rvalid_o with 0xDEAD_BEEF and an err_o pulse, then back to IDLE.
5. Ack arrives exactly in the timeout cycle -> normal rvalid with mem_rdata_i, err_o stays 0.
6. rst_ni asserted in the middle of BUSY -> mem_req_o and busy_o go to 0 immediately, no rvalid, and after release the first tie is granted to the core.
